// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with hex decode, leading-zero blanking and a frame tick.
// Per-digit blinking is compiled in only when the SEG7_BLINK_EN macro is defined.

module seg7_scan_driver_chk #(
    parameter int NUM_DIGITS = 4
) (
    input logic                  i_clk,
    input logic                  i_rst,
    input logic                  en,
    input logic [NUM_DIGITS-1:0] an,
    input logic [6:0]            seg,
    input logic                  frame_tick
);
    // At most one anode may ever be driven low.
    a_an_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(~an));

    // A disabled display drives nothing.
    a_dark_when_off: assert property (@(posedge i_clk) disable iff (i_rst)
        !en |-> (an == {NUM_DIGITS{1'b1}} && seg == 7'h7F));

    // A frame is always longer than one cycle, so ticks never run together.
    a_tick_single: assert property (@(posedge i_clk) disable iff (i_rst)
        frame_tick |=> !frame_tick);
endmodule

module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_lz_blank,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   i_blink,
`endif
    output logic [6:0]              o_7seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_tick
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_cfg
        $error("seg7_scan_driver: illegal parameter set");
    end

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [PRESC_W-1:0]      presc_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] value_r;
    logic                    frame_tick_r;

    logic                    slot_end_s;
    logic                    frame_end_s;
    logic [3:0]              digit_nib_s;
    logic                    zero_run_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic                    lz_blank_s;
    logic                    blink_blank_s;
    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;

    assign slot_end_s  = (presc_r == PRESC_LAST);
    assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);

    // Slot prescaler, digit index, value capture and end-of-frame pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_r      <= {PRESC_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            value_r      <= {(4*NUM_DIGITS){1'b0}};
            frame_tick_r <= 1'b0;
        end else begin
            if (slot_end_s) begin
                presc_r <= {PRESC_W{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IDX_W{1'b0}};
                end else begin
                    idx_r <= idx_r + IDX_W'(1'b1);
                end
            end else begin
                presc_r <= presc_r + PRESC_W'(1'b1);
            end
            frame_tick_r <= frame_end_s;
            if (i_load) begin
                value_r <= i_value;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

    logic [BCNT_W-1:0] blink_cnt_r;
    logic              blink_phase_r;

    // Blink phase flips after every BLINK_FRAMES completed frames.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            blink_cnt_r   <= {BCNT_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (frame_end_s) begin
            if (blink_cnt_r == BCNT_LAST) begin
                blink_cnt_r   <= {BCNT_W{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BCNT_W'(1'b1);
            end
        end else begin
            blink_cnt_r   <= blink_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    assign blink_blank_s = blink_phase_r & i_blink[idx_r];
`else
    assign blink_blank_s = 1'b0;
`endif

    // A digit is a leading zero when it and every digit above it hold zero.
    always_comb begin
        zero_run_s = 1'b1;
        lz_mask_s  = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run_s   = zero_run_s & (value_r[4*k +: 4] == 4'h0);
            lz_mask_s[k] = zero_run_s;
        end
    end

    assign digit_nib_s = value_r[{idx_r, 2'b00} +: 4];
    assign lz_blank_s  = i_lz_blank & lz_mask_s[idx_r];

    // Anode select and segment pattern; blanked digits keep their anode active.
    always_comb begin
        an_s  = {NUM_DIGITS{1'b1}};
        seg_s = 7'h7F;
        if (i_rst || !i_en) begin
            an_s  = {NUM_DIGITS{1'b1}};
            seg_s = 7'h7F;
        end else begin
            an_s[idx_r] = 1'b0;
            if (lz_blank_s || blink_blank_s) begin
                seg_s = 7'h7F;
            end else begin
                seg_s = hex_to_seg(digit_nib_s);
            end
        end
    end

    assign o_an         = an_s;
    assign o_7seg       = seg_s;
    assign o_frame_tick = frame_tick_r;

    seg7_scan_driver_chk #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_chk (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .en         (i_en),
        .an         (an_s),
        .seg        (seg_s),
        .frame_tick (frame_tick_r)
    );

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots, 2-frame blink).
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    logic        clk        = 1'b0;
    logic        i_rst      = 1'b1;
    logic        i_en       = 1'b0;
    logic        i_load     = 1'b0;
    logic [15:0] i_value    = 16'h0000;
    logic        i_lz_blank = 1'b0;
`ifdef SEG7_BLINK_EN
    logic [3:0]  i_blink    = 4'b0000;
`endif
    logic [6:0]  o_7seg;
    logic [3:0]  o_an;
    logic        o_frame_tick;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_load       (i_load),
        .i_value      (i_value),
        .i_lz_blank   (i_lz_blank),
`ifdef SEG7_BLINK_EN
        .i_blink      (i_blink),
`endif
        .o_7seg       (o_7seg),
        .o_an         (o_an),
        .o_frame_tick (o_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst = 1'b1; i_load = 1'b0; i_en = 1'b1; i_lz_blank = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_en = 1'b1; i_load = 1'b1; i_value = 16'hFFFF; i_lz_blank = 1'b0; i_rst = 1'b1;
        step();
        step();
        total++; if (o_an !== 4'hF) begin bad++; $display("FAIL reset_an got=%h want=%h", o_an, 4'hF); end
        total++; if (o_7seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h want=%h", o_7seg, 7'h7F); end
        total++; if (o_frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", o_frame_tick); end
        i_rst = 1'b0; i_load = 1'b0;
        #1;
        total++; if (o_an !== 4'hE) begin bad++; $display("FAIL release_an got=%h want=%h", o_an, 4'hE); end
        total++; if (o_7seg !== 7'h40) begin bad++; $display("FAIL release_seg got=%h want=%h", o_7seg, 7'h40); end
    endtask

    task automatic test_scan();
        logic [6:0] tab [4];
        logic [3:0] exp_an;
        logic       exp_tick;
        int         d;
        tab[0] = 7'h0E; tab[1] = 7'h08; tab[2] = 7'h24; tab[3] = 7'h79;
        apply_reset();
        i_value = 16'h12AF; i_load = 1'b1;
        step();
        i_load = 1'b0;
        for (int p = 1; p <= 33; p++) begin
            d        = (p / 4) % 4;
            exp_an   = ~(4'b0001 << d);
            exp_tick = (p % 16 == 0);
            total++; if (o_an !== exp_an) begin bad++; $display("FAIL scan_an p=%0d got=%h want=%h", p, o_an, exp_an); end
            total++; if (o_7seg !== tab[d]) begin bad++; $display("FAIL scan_seg p=%0d got=%h want=%h", p, o_7seg, tab[d]); end
            total++; if (o_frame_tick !== exp_tick) begin bad++; $display("FAIL scan_tick p=%0d got=%b want=%b", p, o_frame_tick, exp_tick); end
            step();
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0]  tab [3][4];
        logic [15:0] vals [3];
        logic [3:0]  exp_an;
        int          d;
        int          p;
        vals[0] = 16'h0050; tab[0][0] = 7'h40; tab[0][1] = 7'h12; tab[0][2] = 7'h7F; tab[0][3] = 7'h7F;
        vals[1] = 16'h0000; tab[1][0] = 7'h40; tab[1][1] = 7'h7F; tab[1][2] = 7'h7F; tab[1][3] = 7'h7F;
        vals[2] = 16'h0100; tab[2][0] = 7'h40; tab[2][1] = 7'h40; tab[2][2] = 7'h79; tab[2][3] = 7'h7F;
        apply_reset();
        i_lz_blank = 1'b1;
        p = 0;
        for (int v = 0; v < 3; v++) begin
            i_value = vals[v]; i_load = 1'b1;
            step(); p++;
            i_load = 1'b0;
            repeat (16) begin
                d      = (p / 4) % 4;
                exp_an = ~(4'b0001 << d);
                total++; if (o_an !== exp_an) begin bad++; $display("FAIL lz_an v=%0d p=%0d got=%h want=%h", v, p, o_an, exp_an); end
                total++; if (o_7seg !== tab[v][d]) begin bad++; $display("FAIL lz_seg v=%0d p=%0d got=%h want=%h", v, p, o_7seg, tab[v][d]); end
                step(); p++;
            end
        end
        i_lz_blank = 1'b0;
    endtask

    task automatic test_enable();
        logic [6:0] tab [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_tick;
        logic       en_v;
        int         d;
        tab[0] = 7'h0E; tab[1] = 7'h08; tab[2] = 7'h24; tab[3] = 7'h79;
        apply_reset();
        i_value = 16'h12AF; i_load = 1'b1;
        step();
        i_load = 1'b0;
        for (int p = 1; p <= 24; p++) begin
            en_v = !(p >= 6 && p < 13);
            i_en = en_v;
            #1;
            d        = (p / 4) % 4;
            exp_an   = en_v ? ~(4'b0001 << d) : 4'hF;
            exp_seg  = en_v ? tab[d] : 7'h7F;
            exp_tick = (p % 16 == 0);
            total++; if (o_an !== exp_an) begin bad++; $display("FAIL en_an p=%0d got=%h want=%h", p, o_an, exp_an); end
            total++; if (o_7seg !== exp_seg) begin bad++; $display("FAIL en_seg p=%0d got=%h want=%h", p, o_7seg, exp_seg); end
            total++; if (o_frame_tick !== exp_tick) begin bad++; $display("FAIL en_tick p=%0d got=%b want=%b", p, o_frame_tick, exp_tick); end
            step();
        end
        i_en = 1'b1;
    endtask

    task automatic test_load_at_wrap();
        apply_reset();
        i_value = 16'h12AF; i_load = 1'b1;
        step();
        i_load = 1'b0;
        repeat (6) step();
        total++; if (o_an !== 4'hD) begin bad++; $display("FAIL wrap_pre_an got=%h want=%h", o_an, 4'hD); end
        total++; if (o_7seg !== 7'h08) begin bad++; $display("FAIL wrap_pre_seg got=%h want=%h", o_7seg, 7'h08); end
        i_value = 16'h3C00; i_load = 1'b1;
        step();
        i_load = 1'b0;
        total++; if (o_an !== 4'hB) begin bad++; $display("FAIL wrap_an got=%h want=%h", o_an, 4'hB); end
        total++; if (o_7seg !== 7'h46) begin bad++; $display("FAIL wrap_seg got=%h want=%h", o_7seg, 7'h46); end
        repeat (4) step();
        total++; if (o_an !== 4'h7) begin bad++; $display("FAIL wrap_d3_an got=%h want=%h", o_an, 4'h7); end
        total++; if (o_7seg !== 7'h30) begin bad++; $display("FAIL wrap_d3_seg got=%h want=%h", o_7seg, 7'h30); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_an;
        logic       exp_tick;
        apply_reset();
        i_value = 16'h12AF; i_load = 1'b1;
        step();
        i_load = 1'b0;
        repeat (13) step();
        total++; if (o_an !== 4'h7) begin bad++; $display("FAIL mid_pre_an got=%h want=%h", o_an, 4'h7); end
        total++; if (o_7seg !== 7'h79) begin bad++; $display("FAIL mid_pre_seg got=%h want=%h", o_7seg, 7'h79); end
        i_rst = 1'b1;
        #1;
        total++; if (o_an !== 4'hF) begin bad++; $display("FAIL mid_rst_an got=%h want=%h", o_an, 4'hF); end
        total++; if (o_7seg !== 7'h7F) begin bad++; $display("FAIL mid_rst_seg got=%h want=%h", o_7seg, 7'h7F); end
        step();
        i_rst = 1'b0;
        #1;
        for (int q = 0; q <= 16; q++) begin
            exp_an   = ~(4'b0001 << ((q / 4) % 4));
            exp_tick = (q == 16);
            total++; if (o_an !== exp_an) begin bad++; $display("FAIL mid_an q=%0d got=%h want=%h", q, o_an, exp_an); end
            total++; if (o_7seg !== 7'h40) begin bad++; $display("FAIL mid_seg q=%0d got=%h want=%h", q, o_7seg, 7'h40); end
            total++; if (o_frame_tick !== exp_tick) begin bad++; $display("FAIL mid_tick q=%0d got=%b want=%b", q, o_frame_tick, exp_tick); end
            step();
        end
    endtask

`ifdef SEG7_BLINK_EN
    task automatic test_blink();
        logic [6:0] exp_seg;
        int         d;
        i_blink = 4'b0010;
        apply_reset();
        i_value = 16'h8888; i_load = 1'b1;
        step();
        i_load = 1'b0;
        for (int p = 1; p <= 72; p++) begin
            d       = (p / 4) % 4;
            exp_seg = (d == 1 && ((p / 32) % 2) == 1) ? 7'h7F : 7'h00;
            total++; if (o_7seg !== exp_seg) begin bad++; $display("FAIL blink_seg p=%0d got=%h want=%h", p, o_7seg, exp_seg); end
            step();
        end
        i_blink = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_lz_blank();
        test_enable();
        test_load_at_wrap();
        test_reset_mid();
`ifdef SEG7_BLINK_EN
        test_blink();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
